ms_rr_arbiter: RTL and testbench
================================

Name: ms_rr_arbiter

Overview:
- Round-robin scheduler that shares one master-slave output channel (data plus one-cycle sync strobe) among NUM_REQ requesters.
- Sits between several producer modules and a single slave module that samples its input only when the sync strobe is high.
- Sequences the channel with a three-section FSM: idle, transfer, gap. The gap enforces a minimum spacing between transfers.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 32, payload width in bits.
- GAP_CYCLES, 2, idle cycles forced after each transfer (0..15); 0 means no gap section.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  request per requester; held high until its ack.
- req_data  input  NUM_REQ*DATA_W  payload; slice i = bits [i*DATA_W +: DATA_W].
- ack  output  NUM_REQ  one-hot, one-cycle pulse to the served requester.
- s_out  output  DATA_W  registered payload to the slave.
- s_out_sync  output  1  one-cycle strobe; s_out is valid when high.
- grant_id  output  $clog2(NUM_REQ)  index of last/current granted requester.
- busy  output  1  high in the transfer and gap sections.

Behaviour:
- Reset is synchronous: on a clk edge with rst=1, all state is cleared.
  - section <= idle; ack, s_out, s_out_sync, busy, gap counter <= 0.
  - last_grant <= NUM_REQ-1, so requester 0 has top priority after reset.
  - grant_id <= 0.
- rst dominates all other inputs.
- A reset during transfer or gap aborts the operation: the ack/sync pulse is not issued, or is cleared if already issued.
- Idle section:
  - If no req bit is set, stay idle; all outputs other than grant_id and s_out are 0.
  - If any req bit is set, pick g, the first set bit scanning last_grant+1, last_grant+2, ... with modulo NUM_REQ wrap.
  - On that edge register: s_out <= req_data slice g; s_out_sync <= 1; ack[g] <= 1; grant_id <= g; last_grant <= g; busy <= 1; section <= transfer.
- Latency: req sampled high in idle at edge t gives s_out_sync and ack[g] high during cycle t..t+1, i.e. visible one cycle after sampling.
- Transfer section (exactly 1 cycle):
  - Next edge: s_out_sync <= 0; ack <= 0.
  - If GAP_CYCLES>0: section <= gap, counter <= GAP_CYCLES-1.
  - If GAP_CYCLES=0: section <= idle and busy <= 0. Arbitration is not performed on this edge, so the minimum period is 2 cycles.
- Gap section:
  - busy=1 and s_out_sync=0; requests are ignored.
  - When counter==0: section <= idle, busy <= 0. Otherwise decrement the counter.
- s_out holds its last value outside transfers; it is not cleared after a transfer.
- Requesters must drop req in the cycle after ack. A req still high in idle is treated as a new request.
- Requests that drop before being granted are simply not served; there are no errors.
- Fairness: with all req bits continuously high, grants rotate 0,1,...,NUM_REQ-1,0.
  - The period between grants is 2+GAP_CYCLES cycles.
  - No requester waits more than NUM_REQ grants.
- Simultaneous events: ack and s_out_sync always assert in the same cycle, and at most one ack bit is high at a time.
- Assertions:
  - ack is always one-hot or zero.
  - s_out_sync == |ack.
  - s_out_sync is never high on two consecutive cycles.

Test Plan:
- Reset then single request: rst for 2 cycles; req=4'b0100, data[2]=32'hA5A5_0002 → next cycle s_out_sync=1, ack=4'b0100, s_out=32'hA5A5_0002, grant_id=2. busy stays high for 1+GAP_CYCLES=3 cycles, then 0.
- All requesting, GAP_CYCLES=2: req=4'b1111 held, each requester dropping req after its ack and re-raising it 1 cycle later → grant_id sequence 0,1,2,3,0, with sync pulses every 4 cycles.
- Wrap-around priority: last grant 3; req=4'b1001 → grant 0; next arbitration with req=4'b1001 → grant 3.
- Request during gap: req[1] rises in the first gap cycle → no ack until idle; ack[1] arrives exactly one cycle after the section returns to idle.
- Reset mid-operation: assert rst in the cycle s_out_sync=1 → next cycle sync=0, ack=0, busy=0. After release with req=4'b1111, the first grant is 0.
- GAP_CYCLES=0 build: req=4'b0011 held → sync pulses on alternating cycles, grants 0,1,0,1; s_out_sync is never high on consecutive cycles.

Source files
------------

// File: rtl/ms_rr_arbiter.sv
// ms_rr_arbiter: round-robin scheduler sharing one data+sync channel among NUM_REQ requesters.
module ms_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 32,
    parameter int GAP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_W-1:0]             s_out,
    output logic                          s_out_sync,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = 1;
    typedef enum logic [1:0] {IDLE, XFER, GAP} section_t;
    section_t        section;
    logic [3:0]      cnt;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   pick;
    logic            found;
    int              idx;
    // first set request strictly after last_grant, wrapping modulo NUM_REQ
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            section    <= IDLE;
            ack        <= '0;
            s_out      <= '0;
            s_out_sync <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            grant_id   <= '0;
        end else begin
            case (section)
                IDLE: if (found) begin
                    s_out      <= req_data[pick*DATA_W +: DATA_W];
                    s_out_sync <= 1'b1;
                    ack        <= ONE << pick;
                    grant_id   <= pick;
                    last_grant <= pick;
                    busy       <= 1'b1;
                    section    <= XFER;
                end
                XFER: begin
                    s_out_sync <= 1'b0;
                    ack        <= '0;
                    if (GAP_CYCLES > 0) begin
                        section <= GAP;
                        cnt     <= 4'(GAP_CYCLES - 1);
                    end else begin
                        section <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                GAP: if (cnt == 4'd0) begin
                    section <= IDLE;
                    busy    <= 1'b0;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                default: section <= IDLE;
            endcase
        end
    end
    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
    a_sync:   assert property (@(posedge clk) disable iff (rst) s_out_sync == |ack);
    a_space:  assert property (@(posedge clk) disable iff (rst) !(s_out_sync && $past(s_out_sync)));
endmodule

// File: tb/tb_ms_rr_arbiter.sv
// tb_ms_rr_arbiter: directed scenarios for the round-robin channel arbiter (gap=2 and gap=0 builds).
module tb_ms_rr_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = '0;
    logic [127:0] req_data;
    logic [3:0]   ack, ack0;
    logic [31:0]  s_out, s_out0;
    logic         sync, sync0, busy, busy0;
    logic [1:0]   gid, gid0;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ms_rr_arbiter #(.NUM_REQ(4), .DATA_W(32), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .s_out(s_out), .s_out_sync(sync), .grant_id(gid), .busy(busy));

    ms_rr_arbiter #(.NUM_REQ(4), .DATA_W(32), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack0),
        .s_out(s_out0), .s_out_sync(sync0), .grant_id(gid0), .busy(busy0));

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        total++; if (ack !== 4'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        total++; if (sync !== 1'b0) begin bad++; $display("FAIL reset_sync got=%b exp=0", sync); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (gid !== 2'd0) begin bad++; $display("FAIL reset_gid got=%0d exp=0", gid); end
        total++; if (s_out !== 32'h0) begin bad++; $display("FAIL reset_sout got=%h exp=0", s_out); end
        rst = 1'b0;
    endtask

    task automatic test_single;
        req = 4'b0100;
        step(1);
        total++; if (sync !== 1'b1) begin bad++; $display("FAIL single_sync got=%b exp=1", sync); end
        total++; if (ack !== 4'b0100) begin bad++; $display("FAIL single_ack got=%b exp=0100", ack); end
        total++; if (s_out !== 32'hA5A5_0002) begin bad++; $display("FAIL single_sout got=%h exp=a5a50002", s_out); end
        total++; if (gid !== 2'd2) begin bad++; $display("FAIL single_gid got=%0d exp=2", gid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy1 got=%b exp=1", busy); end
        req = 4'b0000;
        step(1);
        total++; if (sync !== 1'b0 || ack !== 4'b0) begin bad++; $display("FAIL single_drop sync=%b ack=%b exp=0/0000", sync, ack); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy2 got=%b exp=1", busy); end
        step(1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy3 got=%b exp=1", busy); end
        step(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy4 got=%b exp=0", busy); end
        total++; if (s_out !== 32'hA5A5_0002) begin bad++; $display("FAIL single_hold got=%h exp=a5a50002", s_out); end
    endtask

    task automatic test_all;
        int expg[5] = '{0, 1, 2, 3, 0};
        int k = 0;
        int prev = 0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        req = 4'b1111;
        for (int c = 1; c <= 17; c++) begin
            step(1);
            if (sync) begin
                if (k < 5) begin
                    total++; if (gid !== 2'(expg[k])) begin bad++; $display("FAIL all_gid%0d got=%0d exp=%0d", k, gid, expg[k]); end
                end
                if (k > 0) begin
                    total++; if (c - prev != 4) begin bad++; $display("FAIL all_period%0d got=%0d exp=4", k, c - prev); end
                end
                prev = c;
                k++;
            end
            req = ~ack;
        end
        total++; if (k != 5) begin bad++; $display("FAIL all_count got=%0d exp=5", k); end
        req = 4'b0000;
        step(3);
    endtask

    task automatic test_wrap;
        req = 4'b1000;
        step(1);
        total++; if (gid !== 2'd3) begin bad++; $display("FAIL wrap_pre got=%0d exp=3", gid); end
        req = 4'b0000;
        step(3);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_idle got=%b exp=0", busy); end
        req = 4'b1001;
        step(1);
        total++; if (gid !== 2'd0 || ack !== 4'b0001) begin bad++; $display("FAIL wrap_first gid=%0d ack=%b exp=0/0001", gid, ack); end
        step(4);
        total++; if (gid !== 2'd3 || ack !== 4'b1000) begin bad++; $display("FAIL wrap_second gid=%0d ack=%b exp=3/1000", gid, ack); end
        req = 4'b0000;
        step(3);
    endtask

    task automatic test_gap_req;
        req = 4'b0001;
        step(1);
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL gap_grant got=%b exp=0001", ack); end
        req = 4'b0000;
        step(1);
        req = 4'b0010;
        step(1);
        total++; if (ack !== 4'b0 || busy !== 1'b1) begin bad++; $display("FAIL gap_hold ack=%b busy=%b exp=0000/1", ack, busy); end
        step(1);
        total++; if (ack !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL gap_idle ack=%b busy=%b exp=0000/0", ack, busy); end
        step(1);
        total++; if (ack !== 4'b0010 || sync !== 1'b1) begin bad++; $display("FAIL gap_served ack=%b sync=%b exp=0010/1", ack, sync); end
        req = 4'b0000;
        step(3);
    endtask

    task automatic test_reset_mid;
        req = 4'b0100;
        step(1);
        total++; if (sync !== 1'b1) begin bad++; $display("FAIL mid_sync got=%b exp=1", sync); end
        rst = 1'b1;
        step(1);
        total++; if (sync !== 1'b0 || ack !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_abort sync=%b ack=%b busy=%b exp=0/0000/0", sync, ack, busy); end
        rst = 1'b0;
        req = 4'b1111;
        step(1);
        total++; if (gid !== 2'd0 || ack !== 4'b0001) begin bad++; $display("FAIL mid_first gid=%0d ack=%b exp=0/0001", gid, ack); end
        req = 4'b0000;
        step(3);
    endtask

    task automatic test_gap0;
        int expg[4] = '{0, 1, 0, 1};
        int k = 0;
        logic prev = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        req = 4'b0011;
        for (int c = 1; c <= 8; c++) begin
            step(1);
            total++; if (sync0 !== 1'(c % 2)) begin bad++; $display("FAIL gap0_sync%0d got=%b exp=%0d", c, sync0, c % 2); end
            total++; if (sync0 && prev) begin bad++; $display("FAIL gap0_consec%0d got=1 exp=0", c); end
            if (sync0 && k < 4) begin
                total++; if (gid0 !== 2'(expg[k])) begin bad++; $display("FAIL gap0_gid%0d got=%0d exp=%0d", k, gid0, expg[k]); end
                k++;
            end
            prev = sync0;
        end
        total++; if (k != 4) begin bad++; $display("FAIL gap0_count got=%0d exp=4", k); end
        req = 4'b0000;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
        step(1);
        test_reset();
        test_single();
        test_all();
        test_wrap();
        test_gap_req();
        test_reset_mid();
        test_gap0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
